// File: rtl/prbs31_seq_ctrl.sv
// rtl/prbs31_seq_ctrl.sv - command-driven PRBS31 (x^31+x^28+1) byte generator/checker sequencer
// Optional checker mode is compiled in with `define PRBS31_CHECK_EN.
module prbs31_seq_ctrl #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    input  logic             chk_valid,
    input  logic [7:0]       chk_data,
    output logic             busy,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_CHK} state_t;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_CHECK = 2'd3;

    // Returns {byte, next_state}; the first generated bit lands in byte bit 7.
    function automatic logic [38:0] byte_step(input logic [30:0] s);
        logic [30:0] t;
        logic [7:0]  b;
        logic        nb;
        t = s;
        b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            nb = t[30] ^ t[27];
            b  = {b[6:0], nb};
            t  = {t[29:0], nb};
        end
        return {b, t};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] seed_reg;
    logic [30:0] lfsr;
    logic        reload;
    logic [8:0]  count;

    logic        is_load, is_start, is_stop, is_check;
    logic [30:0] src, src_nz;
    logic [38:0] src_step, lfsr_step;
    logic        out_xfer, chk_hit, last;
    logic        unused_bits;

    assign is_load  = cmd_valid && (cmd_op == OP_LOAD);
    assign is_start = cmd_valid && (cmd_op == OP_START);
    assign is_stop  = cmd_valid && (cmd_op == OP_STOP);

    assign src       = reload ? seed_reg[30:0] : lfsr;
    assign src_nz    = (src == 31'd0) ? 31'h1 : src;
    assign src_step  = byte_step(src_nz);
    assign lfsr_step = byte_step(lfsr);
    assign out_xfer  = (state_q == ST_GEN) && out_valid && out_ready;
    assign last      = (count == 9'd1);

`ifdef PRBS31_CHECK_EN
    logic [7:0]       exp_byte;
    logic [ERR_W-1:0] err_q;
    assign is_check    = cmd_valid && (cmd_op == OP_CHECK);
    assign chk_hit     = (state_q == ST_CHK) && chk_valid;
    assign err_cnt     = err_q;
    assign unused_bits = seed_reg[31];
`else
    assign is_check    = 1'b0;
    assign chk_hit     = 1'b0;
    assign err_cnt     = '0;
    assign unused_bits = ^{seed_reg[31], chk_valid, chk_data};
`endif

    assign cmd_ready = 1'b1;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (is_start)      state_d = ST_GEN;
                else if (is_check) state_d = ST_CHK;
            end
            ST_GEN:  if (is_stop || (out_xfer && last)) state_d = ST_IDLE;
            ST_CHK:  if (is_stop || (chk_hit && last))  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            seed_reg  <= 32'd0;
            lfsr      <= 31'h1;
            reload    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            count     <= 9'd0;
`ifdef PRBS31_CHECK_EN
            exp_byte  <= 8'd0;
            err_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (is_load) begin
                seed_reg <= {seed_reg[23:0], cmd_data};
                reload   <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (is_start) begin
                        reload    <= 1'b0;
                        lfsr      <= src_step[30:0];
                        out_data  <= src_step[38:31];
                        out_valid <= 1'b1;
                        count     <= (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
                    end
`ifdef PRBS31_CHECK_EN
                    else if (is_check) begin
                        reload   <= 1'b0;
                        lfsr     <= src_step[30:0];
                        exp_byte <= src_step[38:31];
                        err_q    <= '0;
                        count    <= (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
                    end
`endif
                end
                ST_GEN: begin
                    // lfsr always sits just past the byte on out_data; a stop simply drops that byte
                    if (out_xfer) begin
                        count <= count - 9'd1;
                        if (!last && !is_stop) begin
                            out_data <= lfsr_step[38:31];
                            lfsr     <= lfsr_step[30:0];
                        end
                    end
                    if (is_stop || (out_xfer && last)) out_valid <= 1'b0;
                end
`ifdef PRBS31_CHECK_EN
                ST_CHK: begin
                    if (chk_hit) begin
                        if ((chk_data != exp_byte) && (err_q != '1)) err_q <= err_q + ERR_W'(1);
                        count <= count - 9'd1;
                        if (!last) begin
                            exp_byte <= lfsr_step[38:31];
                            lfsr     <= lfsr_step[30:0];
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs31_seq_ctrl.sv
// tb/tb_prbs31_seq_ctrl.sv - randomized self-checking bench for prbs31_seq_ctrl against a sequence model
module tb_prbs31_seq_ctrl;

    localparam int ERR_W = 16;
    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_CHECK = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [7:0]       cmd_data = 8'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             chk_valid = 1'b0;
    logic [7:0]       chk_data = 8'd0;
    logic             busy;
    logic [ERR_W-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: seed shift register, reload flag and the running PRBS31 state.
    logic [31:0] m_seed   = 32'd0;
    logic [30:0] m_lfsr   = 31'h1;
    bit          m_reload = 1'b0;

    prbs31_seq_ctrl #(.ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .chk_valid(chk_valid), .chk_data(chk_data),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_byte();
        logic [7:0] b;
        bit nb;
        b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            nb       = m_lfsr[30] ^ m_lfsr[27];
            b[7 - i] = nb;
            m_lfsr   = {m_lfsr[29:0], nb};
        end
        return b;
    endfunction

    function automatic void m_load(input logic [7:0] d);
        m_seed   = {m_seed[23:0], d};
        m_reload = 1'b1;
    endfunction

    function automatic void m_start();
        logic [30:0] s;
        s = m_reload ? m_seed[30:0] : m_lfsr;
        if (s == 31'd0) s = 31'h1;
        m_lfsr   = s;
        m_reload = 1'b0;
    endfunction

    function automatic void m_reset();
        m_seed   = 32'd0;
        m_lfsr   = 31'h1;
        m_reload = 1'b0;
    endfunction

    task automatic cmd(input logic [1:0] op, input logic [7:0] d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic load_seed(input logic [31:0] s);
        for (int i = 3; i >= 0; i--) begin
            cmd(OP_LOAD, s[i*8 +: 8]);
            m_load(s[i*8 +: 8]);
        end
    endtask

    // Consume n bytes; optionally inject one command when got == inj_at.
    task automatic drain(input int n, input int ready_pct, input int inj_at,
                         input logic [1:0] inj_op, input logic [7:0] inj_data, input bit final_chk);
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        bit injected = 1'b0;
        logic [7:0] held = 8'd0;
        while (got < n && cyc < 5000) begin
            cmd_valid = 1'b0;
            if (!injected && got == inj_at) begin
                injected  = 1'b1;
                cmd_valid = 1'b1;
                cmd_op    = inj_op;
                cmd_data  = inj_data;
                if (inj_op == OP_LOAD) m_load(inj_data);
            end
            out_ready = ($urandom_range(99) < ready_pct);
            check("gen_valid", out_valid, 1'b1);
            if (stalled) check("gen_hold", out_data, held);
            if (out_valid && out_ready) begin
                check("gen_byte", out_data, m_byte());
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = out_data;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        if (got < n) check("gen_timeout", got, n);
        if (final_chk) begin
            check("gen_end_valid", out_valid, 1'b0);
            check("gen_end_busy", busy, 1'b0);
        end
    endtask

    task automatic burst(input int len, input int ready_pct);
        cmd(OP_START, len[7:0]);
        m_start();
        drain((len == 0) ? 256 : len, ready_pct, -1, OP_LOAD, 8'd0, 1'b1);
    endtask

`ifdef PRBS31_CHECK_EN
    // Feed n bytes with gaps; err_pct of them corrupted. Returns the model error count.
    task automatic check_run(input int n, input int err_pct, output int exp_err);
        int got = 0;
        int cyc = 0;
        logic [7:0] b;
        exp_err = 0;
        while (got < n && cyc < 5000) begin
            chk_valid = ($urandom_range(2) != 0);
            if (chk_valid) begin
                b = m_byte();
                if ($urandom_range(99) < err_pct) begin
                    chk_data = b ^ 8'($urandom_range(1, 255));
                    exp_err++;
                end else begin
                    chk_data = b;
                end
                got++;
            end
            check("chk_busy", busy, 1'b1);
            check("chk_no_out", out_valid, 1'b0);
            @(negedge clk);
            cyc++;
        end
        chk_valid = 1'b0;
        if (got < n) check("chk_timeout", got, n);
    endtask
`endif

    initial begin
        int e;
        logic [7:0] first_fresh;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_out_data", out_data, 8'h00);
        rst_n = 1'b1;

        // No seed loaded: source is 31'h1, first two bytes are zero
        cmd(OP_START, 8'd2);
        m_start();
        check("start_latency_valid", out_valid, 1'b1);
        check("start_busy", busy, 1'b1);
        check("seed1_byte0", out_data, 8'h00);
        drain(2, 100, -1, OP_LOAD, 8'd0, 1'b1);

        // Seed 0x40000000 gives 0x80, 0x00
        load_seed(32'h4000_0000);
        cmd(OP_START, 8'd2);
        m_start();
        check("seed40_byte0", out_data, 8'h80);
        drain(2, 100, -1, OP_LOAD, 8'd0, 1'b1);

        // Backpressure: byte held for 5 cycles
        load_seed(32'h4000_0000);
        cmd(OP_START, 8'd3);
        m_start();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, 8'h80);
            @(negedge clk);
        end
        check("bp_cmd_ready", cmd_ready, 1'b1);
        drain(3, 100, -1, OP_LOAD, 8'd0, 1'b1);

        // Length 0 means 256, then continuation without reload
        load_seed(32'h4000_0000);
        burst(0, 80);
        cmd(OP_STOP, 8'd0);
        check("stop_idle_busy", busy, 1'b0);
        cmd(OP_START, 8'd4);
        m_start();
        first_fresh = 8'h80;
        n_checks++;
        assert (out_data !== first_fresh) else begin
            n_errors++;
            $error("FAIL continue_differs: observed %0h expected not %0h", out_data, first_fresh);
        end
        drain(4, 60, -1, OP_LOAD, 8'd0, 1'b1);

        // Zero seed is replaced by 31'h1
        load_seed(32'h0);
        cmd(OP_START, 8'd1);
        m_start();
        check("zero_seed_byte", out_data, 8'h00);
        drain(1, 100, -1, OP_LOAD, 8'd0, 1'b1);

        // LOAD_SEED mid-burst does not disturb it; next START uses the new seed
        load_seed(32'h1234_5678);
        cmd(OP_START, 8'd6);
        m_start();
        drain(6, 70, 2, OP_LOAD, 8'h5A, 1'b1);
        cmd(OP_START, 8'd5);
        m_start();
        drain(5, 100, 1, OP_START, 8'h03, 1'b1);

        // STOP mid-burst with sink stalled: byte on out_data is dropped
        cmd(OP_START, 8'd10);
        m_start();
        drain(3, 100, -1, OP_LOAD, 8'd0, 1'b0);
        cmd(OP_STOP, 8'd0);
        void'(m_byte());
        check("stop_out_valid", out_valid, 1'b0);
        check("stop_busy", busy, 1'b0);
        burst(7, 50);

`ifdef PRBS31_CHECK_EN
        // Directed check run: one corrupted byte
        load_seed(32'h4000_0000);
        cmd(OP_CHECK, 8'd4);
        m_start();
        check("chk_err_cleared", err_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            chk_valid = 1'b1;
            chk_data  = (i == 2) ? 8'hFF : m_byte();
            if (i == 2) void'(m_byte());
            @(negedge clk);
        end
        chk_valid = 1'b0;
        check("chk_dir_err", err_cnt, 1);
        check("chk_dir_busy", busy, 1'b0);
        // chk_valid in IDLE is ignored; err_cnt holds
        chk_valid = 1'b1;
        chk_data  = 8'h55;
        repeat (3) @(negedge clk);
        chk_valid = 1'b0;
        check("chk_idle_hold", err_cnt, 1);

        // STOP mid-check holds err_cnt
        cmd(OP_CHECK, 8'd10);
        m_start();
        check_run(3, 50, e);
        cmd(OP_STOP, 8'd0);
        void'(m_byte());
        check("chk_stop_busy", busy, 1'b0);
        check("chk_stop_err", err_cnt, e);

        for (int k = 0; k < 4; k++) begin
            cmd(OP_CHECK, 8'($urandom_range(1, 30)));
            m_start();
            check_run(int'(dut.count), 30, e);
            check("chk_rand_busy", busy, 1'b0);
            check("chk_rand_err", err_cnt, e);
        end
`else
        // Without the checker, CHECK is accepted and discarded
        cmd(OP_CHECK, 8'd4);
        check("nochk_busy", busy, 1'b0);
        check("nochk_valid", out_valid, 1'b0);
        check("nochk_err", err_cnt, 0);
        burst(3, 100);
`endif

        // Randomized mix of seed loads and bursts
        for (int k = 0; k < 8; k++) begin
            int nl;
            nl = $urandom_range(0, 4);
            for (int j = 0; j < nl; j++) begin
                logic [7:0] d;
                d = 8'($urandom);
                cmd(OP_LOAD, d);
                m_load(d);
            end
            burst($urandom_range(1, 24), $urandom_range(30, 100));
        end

        // Asynchronous reset mid-burst
        cmd(OP_START, 8'd5);
        m_start();
        check("pre_rst_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_data", out_data, 8'h00);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        burst(3, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prbs31_seq_ctrl.md
Name: prbs31_seq_ctrl

Overview:
Command-driven sequencer for the project's PRBS31 (x^31+x^28+1) datapath. Handles seed loading, bursts of generated bytes on a valid/ready stream, and an optional checker mode that compares incoming bytes against the local sequence and counts errors. Sits between the top-level pin decode (ui_in/uio_in) and the uo_out byte driver.

Parameters:
ERR_W, 16, width of the error counter; it saturates at all-ones.

Ports:
clk  in  1  single clock; all state on posedge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  0=LOAD_SEED, 1=START, 2=STOP, 3=CHECK
cmd_data  in  8  seed byte (LOAD_SEED) or burst length (START/CHECK; 0 means 256)
out_valid  out  1  generated byte available
out_ready  in  1  sink accepts byte
out_data  out  8  generated byte
chk_valid  in  1  received byte strobe (checker)
chk_data  in  8  received byte
busy  out  1  state != IDLE
err_cnt  out  ERR_W  mismatches in the current/last CHECK run

Behaviour:
- Reset values: state=IDLE, seed_reg=0, lfsr=31'h1, reload=0, out_valid=0, out_data=0, err_cnt=0, cmd_ready=1, busy=0, count=0.
- LFSR serial step: nb = s[30]^s[27]; s <= {s[29:0], nb}. Byte step = 8 serial steps. The byte equals the 8 nb bits, first-generated in bit 7.
- LOAD_SEED (any state): seed_reg <= {seed_reg[23:0], cmd_data}; reload <= 1. Does not disturb a running burst.
- START/CHECK (IDLE only): lfsr source = reload ? seed_reg[30:0] : lfsr; reload <= 0. A zero source is replaced by 31'h1 to avoid lockup. count <= cmd_data (0 gives 256).
- START or CHECK while busy: accepted (cmd_ready stays 1) and discarded, with no state change.
- STOP: accepted in any state; the next state is IDLE. In IDLE it has no effect.
- States: IDLE, GEN, CHECK.
- IDLE->GEN on START: out_data <= byte(src), lfsr advances 8 steps, out_valid=1 on cycle T+1 after acceptance at T.
- GEN: out_data/out_valid are held stable until out_ready. On a transfer, count decrements. If count was 1, next state is IDLE with out_valid=0. Otherwise the next byte is registered the following cycle, with no bubble.
- STOP in GEN withdraws out_valid on the next cycle. If out_ready is high in the same cycle, that transfer completes, the LFSR is not rolled back, and the unconsumed precomputed byte is discarded (the LFSR is already past it).
- IDLE->CHECK on CHECK: err_cnt <= 0, and the expected byte is precomputed from src. Each chk_valid compares chk_data to the expected byte. A mismatch increments err_cnt, saturating at 2^ERR_W-1. The expected byte then advances and count decrements. When count reaches 0 (or on STOP), the next state is IDLE.
- err_cnt holds its value in IDLE until the next CHECK.
- chk_valid outside CHECK is ignored. out_valid is always 0 in CHECK.
- The LFSR state persists across runs: without a new LOAD_SEED, the next START continues the sequence.
- Reset mid-burst: all registers return to reset values immediately (asynchronous). seed_reg is also cleared.

Optional Feature:
PRBS31_CHECK_EN
- Defined: CHECK mode, chk_* inputs and err_cnt behave as above.
- Undefined: the CHECK opcode is treated as a no-op (accepted and discarded), and err_cnt is tied to 0. No checker logic is synthesised.

Test Plan:
- Reset -> out_valid=0, busy=0, err_cnt=0, cmd_ready=1. Then START len=2 with no seed loaded -> lfsr 31'h1 -> bytes 0x00, 0x00, then IDLE.
- LOAD_SEED 0x40,0x00,0x00,0x00, then START len=2, out_ready=1 -> out_data 0x80 then 0x00; busy drops after the 2nd transfer.
- Same seed, START len=3 with out_ready low for 5 cycles -> out_data is held at 0x80 with out_valid=1 throughout; 3 transfers then total.
- START len=0 -> exactly 256 transfers, then IDLE. A second START without reload continues the sequence (first byte differs from a fresh run).
- LOAD_SEED 0x00 x4, START len=1 -> zero seed replaced by 31'h1 -> byte 0x00, no lockup flag, busy clears.
- PRBS31_CHECK_EN, seed 0x40000000, CHECK len=4, chk_data 0x80,0x00,0xFF,0x00 -> err_cnt=1. STOP mid-run -> IDLE, err_cnt held. Asserting rst_n low mid-GEN -> out_valid=0 immediately.
